sal_cmd_sched: RTL and testbench
================================

Name: sal_cmd_sched

Overview:
Command scheduler at the far end of the per-bank request/grant handshake. It collects ACT/RD/WR/PRE/REF requests from NUM_BANKS bank controllers and grants at most one per cycle. It enforces inter-bank/rank timing (tRRD, tCCD, tWTR, tRTW) and drives the registered DDR2 command/address bus to the PHY. Per-bank timing (tRCD, tRP, tRAS, tRFC, tRTP, tWTP) stays in the bank controllers; requests arriving here are already per-bank legal.

Parameters:
NUM_BANKS, 8, number of bank controllers; also the bank-address range
BA_WIDTH, 3, bank address width, clog2(NUM_BANKS)
RA_WIDTH, 14, row address width
CA_WIDTH, 10, column address width
ADDR_WIDTH, 14, DRAM address bus width; must be >= RA_WIDTH and > 10
TW, 4, width of each inter-bank timing input/counter

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
act_req_i  in  NUM_BANKS  per-bank ACT request
rd_req_i  in  NUM_BANKS  per-bank READ request
wr_req_i  in  NUM_BANKS  per-bank WRITE request
pre_req_i  in  NUM_BANKS  per-bank PRECHARGE request
ref_req_i  in  NUM_BANKS  per-bank REFRESH request
ra_i  in  NUM_BANKS*RA_WIDTH  per-bank row address, bank b at [b*RA_WIDTH +: RA_WIDTH]
ca_i  in  NUM_BANKS*CA_WIDTH  per-bank column address, same packing
t_rrd_i, t_ccd_i, t_wtr_i, t_rtw_i  in  TW each  timing values in clk cycles
act_gnt_o, rd_gnt_o, wr_gnt_o, pre_gnt_o, ref_gnt_o  out  NUM_BANKS each  combinational same-cycle grants
dram_cs_n_o, dram_ras_n_o, dram_cas_n_o, dram_we_n_o  out  1 each  registered command
dram_ba_o  out  BA_WIDTH  registered bank address
dram_addr_o  out  ADDR_WIDTH  registered address

Behaviour:
- Reset (rst_n=0 at posedge): all timing counters 0, RR pointers 0, command regs = NOP (cs_n=1, ras_n=cas_n=we_n=1, ba=0, addr=0). All grants forced 0 while rst_n=0. Reset mid-operation drops any pending command the same edge.
- Grants are combinational from requests and counter state. Exactly zero or one bit is set across all five grant vectors in any cycle. A grant is only ever given to an asserted request.
- Class priority, highest first: REF > RD/WR > ACT > PRE. A class is eligible only if it has a request that passes its timing checks; otherwise the next class is considered.
- Eligibility:
  - ACT needs rrd_cnt==0.
  - RD needs ccd_cnt==0 and wtr_cnt==0.
  - WR needs ccd_cnt==0 and rtw_cnt==0.
  - PRE and REF are always eligible.
  - RD and WR form one column class. Bank selection uses the OR of eligible rd/wr requests; a bank never asserts both.
- Within a class, bank selection follows the Optional Feature. Each class (REF, COL, ACT, PRE) has its own pointer.
- Counters (TW bits, saturating decrement to 0 each cycle):
  - On an ACT grant, rrd_cnt loads t_rrd_i-1.
  - On an RD or WR grant, ccd_cnt loads t_ccd_i-1.
  - On a WR grant, wtr_cnt loads t_wtr_i-1.
  - On an RD grant, rtw_cnt loads t_rtw_i-1.
  - A timing value of 0 loads 0.
  - Net effect: a command at cycle c allows the dependent command at cycle c+t.
  - Load has precedence over decrement in the same cycle.
- Command register, updated at the posedge following the grant (1-cycle latency). Encoding as cs_n/ras_n/cas_n/we_n:
  - ACT = 0/0/1/1, addr = zero-extended ra of the granted bank.
  - RD = 0/1/0/1, addr = ca with addr[10]=0.
  - WR = 0/1/0/0, addr = ca with addr[10]=0.
  - PRE = 0/0/1/0, addr = 0 (A10=0, single bank).
  - REF = 0/0/0/1, addr = 0.
  - No grant gives NOP with ba and addr held.
  - ba = index of the granted bank.
- Simultaneous requests from all banks in all classes: only the REF winner is granted. Lower classes wait with no loss of requests; bank controllers hold requests until granted.

Optional Feature:
SAL_SCHED_RR_EN
- Defined: per-class round-robin. The search starts at that class's pointer. After a grant, the pointer moves to (winner+1) mod NUM_BANKS, wrapping NUM_BANKS-1 -> 0. Other class pointers are unchanged.
- Undefined: fixed priority, lowest bank index wins. Pointers are not implemented.

Test Plan:
1. Reset then idle, no requests -> all grants 0, and cs_n=1 on every cycle.
2. act_req_i=8'h01, ra bank0=14'h123 at cycle 5 -> act_gnt_o=8'h01 in cycle 5. At cycle 6: ras_n=0, cas_n=1, we_n=1, ba=0, addr=14'h0123.
3. t_rrd=3; act_req_i=8'h06 held -> bank1 granted at c, bank2 at c+3, no ACT grant at c+1 or c+2. With RR: a further request from bank1 only at c+3 still loses to bank2.
4. t_wtr=4; wr_req bank0 granted at c, rd_req bank1 asserted from c+1 -> rd_gnt_o=8'h02 first at c+4. Register at c+5 shows cas_n=0, we_n=1, addr[10]=0.
5. All five request vectors = 8'hFF (RR enabled) -> ref_gnt_o=01,02,04,... on successive cycles. act/pre/col grants stay 0 until ref_req deasserts.
6. rst_n low for 1 cycle while a command is queued -> next cycle cs_n=1, counters 0. An RD at the following cycle is granted immediately despite the prior WR.

Source files
------------

// File: rtl/sal_cmd_sched.sv
// DDR2 command scheduler: one grant per cycle across REF > RD/WR > ACT > PRE, inter-bank timing, registered command bus.
// Build option: define SAL_SCHED_RR_EN for per-class round-robin bank selection; otherwise the lowest bank index wins.
module sal_cmd_sched #(
    parameter int NUM_BANKS  = 8,
    parameter int BA_WIDTH   = 3,
    parameter int RA_WIDTH   = 14,
    parameter int CA_WIDTH   = 10,
    parameter int ADDR_WIDTH = 14,
    parameter int TW         = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_BANKS-1:0]          act_req_i,
    input  logic [NUM_BANKS-1:0]          rd_req_i,
    input  logic [NUM_BANKS-1:0]          wr_req_i,
    input  logic [NUM_BANKS-1:0]          pre_req_i,
    input  logic [NUM_BANKS-1:0]          ref_req_i,
    input  logic [NUM_BANKS*RA_WIDTH-1:0] ra_i,
    input  logic [NUM_BANKS*CA_WIDTH-1:0] ca_i,
    input  logic [TW-1:0]                 t_rrd_i,
    input  logic [TW-1:0]                 t_ccd_i,
    input  logic [TW-1:0]                 t_wtr_i,
    input  logic [TW-1:0]                 t_rtw_i,
    output logic [NUM_BANKS-1:0]          act_gnt_o,
    output logic [NUM_BANKS-1:0]          rd_gnt_o,
    output logic [NUM_BANKS-1:0]          wr_gnt_o,
    output logic [NUM_BANKS-1:0]          pre_gnt_o,
    output logic [NUM_BANKS-1:0]          ref_gnt_o,
    output logic                          dram_cs_n_o,
    output logic                          dram_ras_n_o,
    output logic                          dram_cas_n_o,
    output logic                          dram_we_n_o,
    output logic [BA_WIDTH-1:0]           dram_ba_o,
    output logic [ADDR_WIDTH-1:0]         dram_addr_o
);

    typedef enum logic [2:0] {
        CLS_NONE,
        CLS_REF,
        CLS_COL,
        CLS_ACT,
        CLS_PRE
    } cls_e;

    cls_e                  cls;
    logic [BA_WIDTH-1:0]   win;
    logic [NUM_BANKS-1:0]  win_onehot;
    logic [NUM_BANKS-1:0]  col_elig;
    logic [NUM_BANKS-1:0]  act_elig;
    logic                  rd_ok;
    logic                  wr_ok;
    logic                  act_ok;
    logic                  rd_fire;
    logic                  wr_fire;
    logic [RA_WIDTH-1:0]   ra_sel;
    logic [CA_WIDTH-1:0]   ca_sel;
    logic [ADDR_WIDTH-1:0] col_addr;
    logic [TW-1:0]         rrd_cnt;
    logic [TW-1:0]         ccd_cnt;
    logic [TW-1:0]         wtr_cnt;
    logic [TW-1:0]         rtw_cnt;
    logic [BA_WIDTH-1:0]   ref_ptr;
    logic [BA_WIDTH-1:0]   col_ptr;
    logic [BA_WIDTH-1:0]   act_ptr;
    logic [BA_WIDTH-1:0]   pre_ptr;

    // First requesting bank at or after ptr, wrapping; ptr of 0 gives plain lowest-index priority.
    function automatic logic [BA_WIDTH-1:0] pick(input logic [NUM_BANKS-1:0] req,
                                                 input logic [BA_WIDTH-1:0]  ptr);
        logic [BA_WIDTH-1:0] sel;
        int                  idx;
        sel = '0;
        for (int i = NUM_BANKS - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % NUM_BANKS;
            if (req[idx]) sel = BA_WIDTH'(idx);
        end
        return sel;
    endfunction

    function automatic logic [TW-1:0] load_val(input logic [TW-1:0] t);
        return (t == '0) ? '0 : t - TW'(1);
    endfunction

    function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] c);
        return (c == '0) ? '0 : c - TW'(1);
    endfunction

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        cls      = CLS_NONE;
        win      = '0;
        rd_ok    = (ccd_cnt == '0) && (wtr_cnt == '0);
        wr_ok    = (ccd_cnt == '0) && (rtw_cnt == '0);
        act_ok   = (rrd_cnt == '0);
        col_elig = (rd_req_i & {NUM_BANKS{rd_ok}}) | (wr_req_i & {NUM_BANKS{wr_ok}});
        act_elig = act_req_i & {NUM_BANKS{act_ok}};

        if (!rst_n) begin
            cls = CLS_NONE;
        end else if (|ref_req_i) begin
            cls = CLS_REF;
            win = pick(ref_req_i, ref_ptr);
        end else if (|col_elig) begin
            cls = CLS_COL;
            win = pick(col_elig, col_ptr);
        end else if (|act_elig) begin
            cls = CLS_ACT;
            win = pick(act_elig, act_ptr);
        end else if (|pre_req_i) begin
            cls = CLS_PRE;
            win = pick(pre_req_i, pre_ptr);
        end

        win_onehot = {{(NUM_BANKS-1){1'b0}}, 1'b1} << win;
        ref_gnt_o  = (cls == CLS_REF) ? win_onehot : '0;
        act_gnt_o  = (cls == CLS_ACT) ? win_onehot : '0;
        pre_gnt_o  = (cls == CLS_PRE) ? win_onehot : '0;
        rd_gnt_o   = (cls == CLS_COL) ? (win_onehot & rd_req_i & {NUM_BANKS{rd_ok}}) : '0;
        // A misbehaving bank raising both RD and WR still yields a single grant.
        wr_gnt_o   = (cls == CLS_COL) ? (win_onehot & wr_req_i & {NUM_BANKS{wr_ok}} & ~rd_gnt_o) : '0;
        rd_fire    = |rd_gnt_o;
        wr_fire    = |wr_gnt_o;

        ra_sel          = ra_i[win*RA_WIDTH +: RA_WIDTH];
        ca_sel          = ca_i[win*CA_WIDTH +: CA_WIDTH];
        col_addr        = ADDR_WIDTH'(ca_sel);
        col_addr[10]    = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rrd_cnt <= '0;
            ccd_cnt <= '0;
            wtr_cnt <= '0;
            rtw_cnt <= '0;
        end else begin
            rrd_cnt <= (cls == CLS_ACT)    ? load_val(t_rrd_i) : sat_dec(rrd_cnt);
            ccd_cnt <= (rd_fire | wr_fire) ? load_val(t_ccd_i) : sat_dec(ccd_cnt);
            wtr_cnt <= wr_fire             ? load_val(t_wtr_i) : sat_dec(wtr_cnt);
            rtw_cnt <= rd_fire             ? load_val(t_rtw_i) : sat_dec(rtw_cnt);
        end
    end

`ifdef SAL_SCHED_RR_EN
    logic [BA_WIDTH-1:0] win_next;
    assign win_next = (win == BA_WIDTH'(NUM_BANKS - 1)) ? '0 : win + BA_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ref_ptr <= '0;
            col_ptr <= '0;
            act_ptr <= '0;
            pre_ptr <= '0;
        end else begin
            case (cls)
                CLS_REF: ref_ptr <= win_next;
                CLS_COL: col_ptr <= win_next;
                CLS_ACT: act_ptr <= win_next;
                CLS_PRE: pre_ptr <= win_next;
                default: ;
            endcase
        end
    end
`else
    assign ref_ptr = '0;
    assign col_ptr = '0;
    assign act_ptr = '0;
    assign pre_ptr = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {dram_cs_n_o, dram_ras_n_o, dram_cas_n_o, dram_we_n_o} <= 4'b1111;
            dram_ba_o   <= '0;
            dram_addr_o <= '0;
        end else begin
            if (cls != CLS_NONE) dram_ba_o <= win;
            case (cls)
                CLS_REF: begin
                    {dram_cs_n_o, dram_ras_n_o, dram_cas_n_o, dram_we_n_o} <= 4'b0001;
                    dram_addr_o <= '0;
                end
                CLS_COL: begin
                    {dram_cs_n_o, dram_ras_n_o, dram_cas_n_o, dram_we_n_o} <= {3'b010, ~wr_fire};
                    dram_addr_o <= col_addr;
                end
                CLS_ACT: begin
                    {dram_cs_n_o, dram_ras_n_o, dram_cas_n_o, dram_we_n_o} <= 4'b0011;
                    dram_addr_o <= ADDR_WIDTH'(ra_sel);
                end
                CLS_PRE: begin
                    {dram_cs_n_o, dram_ras_n_o, dram_cas_n_o, dram_we_n_o} <= 4'b0010;
                    dram_addr_o <= '0;
                end
                default: {dram_cs_n_o, dram_ras_n_o, dram_cas_n_o, dram_we_n_o} <= 4'b1111;
            endcase
        end
    end

endmodule

// File: tb/tb_sal_cmd_sched.sv
// Directed self-checking bench for sal_cmd_sched; expectations follow SAL_SCHED_RR_EN when it is defined.
module tb_sal_cmd_sched;

    localparam int NB = 8;
`ifdef SAL_SCHED_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NB-1:0] act_req, rd_req, wr_req, pre_req, ref_req;
    logic [NB*14-1:0] ra;
    logic [NB*10-1:0] ca;
    logic [3:0]    t_rrd, t_ccd, t_wtr, t_rtw;
    logic [NB-1:0] act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
    logic          cs_n, ras_n, cas_n, we_n;
    logic [2:0]    ba;
    logic [13:0]   addr;

    int n_checks = 0;
    int n_fail   = 0;

    wire [5*NB-1:0] all_gnt = {act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt};
    wire [20:0]     cmd     = {cs_n, ras_n, cas_n, we_n, ba, addr};

    always #5 clk = ~clk;

    sal_cmd_sched dut (
        .clk(clk), .rst_n(rst_n),
        .act_req_i(act_req), .rd_req_i(rd_req), .wr_req_i(wr_req),
        .pre_req_i(pre_req), .ref_req_i(ref_req),
        .ra_i(ra), .ca_i(ca),
        .t_rrd_i(t_rrd), .t_ccd_i(t_ccd), .t_wtr_i(t_wtr), .t_rtw_i(t_rtw),
        .act_gnt_o(act_gnt), .rd_gnt_o(rd_gnt), .wr_gnt_o(wr_gnt),
        .pre_gnt_o(pre_gnt), .ref_gnt_o(ref_gnt),
        .dram_cs_n_o(cs_n), .dram_ras_n_o(ras_n), .dram_cas_n_o(cas_n),
        .dram_we_n_o(we_n), .dram_ba_o(ba), .dram_addr_o(addr)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        act_req = '0; rd_req = '0; wr_req = '0; pre_req = '0; ref_req = '0;
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; act_req = '1; ref_req = '1;
        mid();
        n_checks++;
        if (all_gnt !== '0) begin n_fail++; $display("FAIL reset_gnt_forced got %h want 0", all_gnt); end
        cyc(); mid();
        n_checks++;
        if (cmd !== {4'b1111, 3'd0, 14'h0}) begin n_fail++; $display("FAIL reset_cmd got %h want NOP", cmd); end
        cyc(); rst_n = 1'b1; act_req = '0; ref_req = '0;
        for (int i = 0; i < 3; i++) begin
            mid();
            n_checks++;
            if ({all_gnt, cs_n} !== {40'h0, 1'b1}) begin
                n_fail++; $display("FAIL idle_%0d gnt %h cs_n %b want 0/1", i, all_gnt, cs_n);
            end
            cyc();
        end
    endtask

    task automatic test_act_basic();
        ra[0*14 +: 14] = 14'h123; act_req = 8'h01;
        mid();
        n_checks++;
        if (all_gnt !== {8'h01, 32'h0}) begin n_fail++; $display("FAIL act_gnt got %h want act=01 only", all_gnt); end
        cyc(); act_req = '0;
        mid();
        n_checks++;
        if (cmd !== {4'b0011, 3'd0, 14'h0123}) begin n_fail++; $display("FAIL act_cmd got %h want %h", cmd, {4'b0011, 3'd0, 14'h0123}); end
        idle(2);
    endtask

    task automatic test_trrd();
        t_rrd = 4'd3; ra[1*14 +: 14] = 14'h1111; ra[2*14 +: 14] = 14'h2222; act_req = 8'h06;
        mid();
        n_checks++;
        if (act_gnt !== 8'h02) begin n_fail++; $display("FAIL trrd_c0 got %h want 02", act_gnt); end
        cyc(); act_req = 8'h04;
        mid();
        n_checks++;
        if ({act_gnt, cmd} !== {8'h00, 4'b0011, 3'd1, 14'h1111}) begin
            n_fail++; $display("FAIL trrd_c1 gnt %h cmd %h want 00 / ACT b1 1111", act_gnt, cmd);
        end
        cyc();
        mid();
        n_checks++;
        if ({act_gnt, cmd} !== {8'h00, 4'b1111, 3'd1, 14'h1111}) begin
            n_fail++; $display("FAIL trrd_c2_hold gnt %h cmd %h want 00 / NOP b1 1111", act_gnt, cmd);
        end
        cyc(); act_req = 8'h06;
        mid();
        n_checks++;
        if (act_gnt !== (RR ? 8'h04 : 8'h02)) begin
            n_fail++; $display("FAIL trrd_c3 got %h want %h", act_gnt, RR ? 8'h04 : 8'h02);
        end
        t_rrd = 4'd1;
        idle(4);
    endtask

    task automatic test_wtr();
        t_wtr = 4'd4; ca[0*10 +: 10] = 10'h3FF; ca[1*10 +: 10] = 10'h2AA; wr_req = 8'h01;
        mid();
        n_checks++;
        if (all_gnt !== {16'h0, 8'h01, 16'h0}) begin n_fail++; $display("FAIL wtr_wr_gnt got %h want wr=01", all_gnt); end
        cyc(); wr_req = '0; rd_req = 8'h02;
        mid();
        n_checks++;
        if ({rd_gnt, cmd} !== {8'h00, 4'b0100, 3'd0, 14'h03FF}) begin
            n_fail++; $display("FAIL wtr_c1 rd %h cmd %h want 00 / WR b0 03ff", rd_gnt, cmd);
        end
        for (int k = 2; k < 4; k++) begin
            cyc(); mid();
            n_checks++;
            if (rd_gnt !== 8'h00) begin n_fail++; $display("FAIL wtr_c%0d rd got %h want 00", k, rd_gnt); end
        end
        cyc(); mid();
        n_checks++;
        if (rd_gnt !== 8'h02) begin n_fail++; $display("FAIL wtr_c4 rd got %h want 02", rd_gnt); end
        cyc(); rd_req = '0;
        mid();
        n_checks++;
        if (cmd !== {4'b0101, 3'd1, 14'h02AA}) begin n_fail++; $display("FAIL wtr_rd_cmd got %h want RD b1 02aa", cmd); end
        idle(2);
    endtask

    task automatic test_rtw_ccd();
        t_rtw = 4'd2; t_ccd = 4'd2; rd_req = 8'h04;
        mid();
        n_checks++;
        if (rd_gnt !== 8'h04) begin n_fail++; $display("FAIL rtw_rd got %h want 04", rd_gnt); end
        cyc(); rd_req = '0; wr_req = 8'h08;
        mid();
        n_checks++;
        if (wr_gnt !== 8'h00) begin n_fail++; $display("FAIL rtw_blocked got %h want 00", wr_gnt); end
        cyc(); mid();
        n_checks++;
        if (wr_gnt !== 8'h08) begin n_fail++; $display("FAIL rtw_wr got %h want 08", wr_gnt); end
        t_rtw = 4'd1; t_ccd = 4'd1;
        idle(5);
    endtask

    task automatic test_priority();
        act_req = 8'h01; pre_req = 8'h02; rd_req = 8'h10;
        mid();
        n_checks++;
        if (all_gnt !== {8'h00, 8'h10, 24'h0}) begin n_fail++; $display("FAIL prio_col got %h want rd=10", all_gnt); end
        cyc(); rd_req = '0;
        mid();
        n_checks++;
        if (all_gnt !== {8'h01, 32'h0}) begin n_fail++; $display("FAIL prio_act got %h want act=01", all_gnt); end
        cyc(); act_req = '0;
        mid();
        n_checks++;
        if (all_gnt !== {24'h0, 8'h02, 8'h00}) begin n_fail++; $display("FAIL prio_pre got %h want pre=02", all_gnt); end
        cyc(); pre_req = '0;
        mid();
        n_checks++;
        if (cmd !== {4'b0010, 3'd1, 14'h0}) begin n_fail++; $display("FAIL pre_cmd got %h want PRE b1 0", cmd); end
        idle(2);
    endtask

    task automatic test_all_ff();
        logic [7:0] e;
        logic [2:0] pb;
        act_req = '1; rd_req = '1; wr_req = '1; pre_req = '1; ref_req = '1;
        for (int i = 0; i < 10; i++) begin
            mid();
            e = RR ? (8'h01 << (i % 8)) : 8'h01;
            n_checks++;
            if (all_gnt !== {32'h0, e}) begin n_fail++; $display("FAIL ff_ref_%0d got %h want ref=%h only", i, all_gnt, e); end
            if (i > 0) begin
                pb = RR ? 3'((i - 1) % 8) : 3'd0;
                n_checks++;
                if (cmd !== {4'b0001, pb, 14'h0}) begin n_fail++; $display("FAIL ff_ref_cmd_%0d got %h want REF b%0d", i, cmd, pb); end
            end
            cyc();
        end
        ref_req = '0; wr_req = '0;
        mid();
        e = RR ? 8'h20 : 8'h01;
        n_checks++;
        if (all_gnt !== {8'h00, e, 24'h0}) begin n_fail++; $display("FAIL ff_col got %h want rd=%h only", all_gnt, e); end
        idle(3);
    endtask

    task automatic test_reset_mid();
        t_wtr = 4'd4; wr_req = 8'h01;
        mid();
        n_checks++;
        if (wr_gnt !== 8'h01) begin n_fail++; $display("FAIL rm_wr got %h want 01", wr_gnt); end
        cyc(); wr_req = '0; rd_req = 8'h02; rst_n = 1'b0;
        mid();
        n_checks++;
        if ({all_gnt, cs_n} !== {40'h0, 1'b0}) begin n_fail++; $display("FAIL rm_in_reset gnt %h cs_n %b want 0/0", all_gnt, cs_n); end
        cyc(); rst_n = 1'b1;
        mid();
        n_checks++;
        if ({rd_gnt, cmd} !== {8'h02, 4'b1111, 3'd0, 14'h0}) begin
            n_fail++; $display("FAIL rm_after gnt %h cmd %h want 02 / NOP", rd_gnt, cmd);
        end
        idle(2);
    endtask

    initial begin
        rst_n = 1'b0; ra = '0; ca = '0;
        act_req = '0; rd_req = '0; wr_req = '0; pre_req = '0; ref_req = '0;
        t_rrd = 4'd1; t_ccd = 4'd1; t_wtr = 4'd1; t_rtw = 4'd1;
        #1;
        test_reset();
        test_act_basic();
        test_trrd();
        test_wtr();
        test_rtw_ccd();
        test_priority();
        test_all_ff();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
